// File: rtl/timeslice_arbiter.sv
// Round-robin time-slice arbiter: each winner owns the shared counter datapath for
// at most quantum+1 cycles, followed by a mandatory one-cycle turnaround gap.
module timeslice_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned QW = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [QW-1:0] quantum,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id,
    output logic          busy,
    output logic [QW-1:0] slice_cnt,
    output logic          expire
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [QW-1:0] r_q_lat;
    logic [N-1:0]  r_grant;
    logic [IW-1:0] r_grant_id;
    logic          r_busy;
    logic [QW-1:0] r_slice_cnt;
    logic          r_expire;

    logic          w_any;
    logic [IW-1:0] w_winner;
    logic [IW-1:0] w_scan;
    logic [IW-1:0] w_next_ptr;
    logic          w_owner_req;

    // First requester at or above r_ptr, wrapping modulo N.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_ptr;
        w_scan   = r_ptr;
        for (int i = 0; i < int'(N); i++) begin
            if (!w_any && req[w_scan]) begin
                w_any    = 1'b1;
                w_winner = w_scan;
            end
            w_scan = (w_scan == IW'(N - 1)) ? '0 : w_scan + IW'(1);
        end
    end

    assign w_next_ptr  = (r_grant_id == IW'(N - 1)) ? '0 : r_grant_id + IW'(1);
    assign w_owner_req = req[r_grant_id];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_q_lat     <= '0;
            r_grant     <= '0;
            r_grant_id  <= '0;
            r_busy      <= 1'b0;
            r_slice_cnt <= '0;
            r_expire    <= 1'b0;
        end else begin
            r_expire <= 1'b0;
            case (r_state)
                S_IDLE, S_GAP: begin
                    if (w_any) begin
                        r_grant     <= {{(N-1){1'b0}}, 1'b1} << w_winner;
                        r_grant_id  <= w_winner;
                        r_q_lat     <= quantum;
                        r_slice_cnt <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_GRANT;
                    end else begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    // A request drop wins over a coincident expiry, so no expire pulse then.
                    if (!w_owner_req || (r_slice_cnt == r_q_lat)) begin
                        r_grant     <= '0;
                        r_busy      <= 1'b0;
                        r_expire    <= w_owner_req;
                        r_ptr       <= w_next_ptr;
                        r_slice_cnt <= '0;
                        r_state     <= S_GAP;
                    end else begin
                        r_slice_cnt <= r_slice_cnt + QW'(1);
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign grant_id  = r_grant_id;
    assign busy      = r_busy;
    assign slice_cnt = r_slice_cnt;
    assign expire    = r_expire;

endmodule

// File: tb/tb_timeslice_arbiter.sv
// Scoreboard bench for timeslice_arbiter: directed steps queue the hand-derived
// outputs expected after each edge; a negedge monitor pops and compares them.
module tb_timeslice_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] quantum;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic [3:0] slice_cnt;
    logic       expire;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] id;
        logic       busy;
        logic [3:0] slice;
        logic       expire;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    timeslice_arbiter #(.N(4), .QW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .quantum   (quantum),
        .grant     (grant),
        .grant_id  (grant_id),
        .busy      (busy),
        .slice_cnt (slice_cnt),
        .expire    (expire)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] id,
                                input logic [3:0] s, input logic e);
        exp_t x;
        x.grant  = g;
        x.id     = id;
        x.busy   = (g != 4'b0000);
        x.slice  = s;
        x.expire = e;
        return x;
    endfunction

    // Drive inputs, take one edge, queue the outputs expected after that edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] q,
                        input exp_t e, input string nm);
        reset   = r;
        req     = rq;
        quantum = q;
        @(posedge clk);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    // Monitor: outputs are stable at the negedge following each edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = mk(grant, grant_id, slice_cnt, expire);
            a.busy = busy;
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got grant=%b id=%0d busy=%b slice=%0d expire=%b, want grant=%b id=%0d busy=%b slice=%0d expire=%b",
                         nm, a.grant, a.id, a.busy, a.slice, a.expire,
                         e.grant, e.id, e.busy, e.slice, e.expire);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] oh;
        reset   = 1'b1;
        req     = 4'b0000;
        quantum = 4'd0;

        // Reset held with all requests asserted
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'b1111, 4'd2, mk(4'b0000, 2'd0, 4'd0, 1'b0), "reset_hold");

        // Rotation with quantum 2: 3-cycle slices, expiring gaps
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            for (int c = 0; c < 3; c++)
                step(1'b0, 4'b1111, 4'd2, mk(oh, 2'(k % 4), 4'(c), 1'b0), "rotate_slice");
            step(1'b0, 4'b1111, 4'd2, mk(4'b0000, 2'(k % 4), 4'd0, 1'b1), "rotate_gap");
        end
        step(1'b0, 4'b0000, 4'd2, mk(4'b0000, 2'd0, 4'd0, 1'b0), "rotate_idle");

        // Early release: req0 low during the 5th grant cycle
        for (int c = 0; c < 5; c++)
            step(1'b0, 4'b0001, 4'd15, mk(4'b0001, 2'd0, 4'(c), 1'b0), "early_slice");
        step(1'b0, 4'b0000, 4'd15, mk(4'b0000, 2'd0, 4'd0, 1'b0), "early_release");
        step(1'b0, 4'b0000, 4'd15, mk(4'b0000, 2'd0, 4'd0, 1'b0), "early_idle");

        // Full-range quantum: 16-cycle slice for requester 1, then re-grant
        for (int c = 0; c < 16; c++)
            step(1'b0, 4'b0010, 4'd15, mk(4'b0010, 2'd1, 4'(c), 1'b0), "full_slice");
        step(1'b0, 4'b0010, 4'd15, mk(4'b0000, 2'd1, 4'd0, 1'b1), "full_expire");
        step(1'b0, 4'b0010, 4'd15, mk(4'b0010, 2'd1, 4'd0, 1'b0), "full_regrant");
        step(1'b0, 4'b0000, 4'd15, mk(4'b0000, 2'd1, 4'd0, 1'b0), "full_release");
        step(1'b0, 4'b0000, 4'd15, mk(4'b0000, 2'd1, 4'd0, 1'b0), "full_idle");

        // Owner drop on the expiry edge counts as a release
        step(1'b0, 4'b0100, 4'd1, mk(4'b0100, 2'd2, 4'd0, 1'b0), "simul_grant");
        step(1'b0, 4'b0100, 4'd1, mk(4'b0100, 2'd2, 4'd1, 1'b0), "simul_slice");
        step(1'b0, 4'b0000, 4'd1, mk(4'b0000, 2'd2, 4'd0, 1'b0), "simul_no_expire");
        step(1'b0, 4'b0000, 4'd1, mk(4'b0000, 2'd2, 4'd0, 1'b0), "simul_idle");

        // Quantum changed mid-slice (down then up) leaves the slice at 3 cycles
        step(1'b0, 4'b1000, 4'd2, mk(4'b1000, 2'd3, 4'd0, 1'b0), "qchg_grant");
        step(1'b0, 4'b1000, 4'd0, mk(4'b1000, 2'd3, 4'd1, 1'b0), "qchg_lower");
        step(1'b0, 4'b1000, 4'd7, mk(4'b1000, 2'd3, 4'd2, 1'b0), "qchg_raise");
        step(1'b0, 4'b1000, 4'd7, mk(4'b0000, 2'd3, 4'd0, 1'b1), "qchg_expire");
        step(1'b0, 4'b0000, 4'd7, mk(4'b0000, 2'd3, 4'd0, 1'b0), "qchg_idle");

        // Reset mid-grant with ptr moved away from 0
        step(1'b0, 4'b0100, 4'd0, mk(4'b0100, 2'd2, 4'd0, 1'b0), "rst_pre_grant");
        step(1'b0, 4'b0100, 4'd0, mk(4'b0000, 2'd2, 4'd0, 1'b1), "rst_pre_expire");
        step(1'b0, 4'b0100, 4'd7, mk(4'b0100, 2'd2, 4'd0, 1'b0), "rst_gap_grant");
        for (int c = 1; c < 4; c++)
            step(1'b0, 4'b0100, 4'd7, mk(4'b0100, 2'd2, 4'(c), 1'b0), "rst_slice");
        step(1'b1, 4'b0100, 4'd7, mk(4'b0000, 2'd0, 4'd0, 1'b0), "rst_mid_grant");
        step(1'b0, 4'b1111, 4'd2, mk(4'b0001, 2'd0, 4'd0, 1'b0), "rst_ptr_zero");
        step(1'b0, 4'b1111, 4'd2, mk(4'b0001, 2'd0, 4'd1, 1'b0), "rst_after_slice");

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
